fifo_stream_reader: RTL
=======================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, depth of the attached synchronous FIFO; sets the `rd_count` width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port en  input  1  read enable; 0 blocks new FIFO reads; outstanding data still drains.
REQ-006 Port r_en  output  1  FIFO read strobe.
REQ-007 Port empty  input  1  FIFO empty flag.
REQ-008 Port data_out  input  WIDTH  FIFO read data; valid exactly 1 cycle after an accepted `r_en`.
REQ-009 Port m_valid  output  1  output stream word valid.
REQ-010 Port m_data  output  WIDTH  output stream word.
REQ-011 Port m_ready  input  1  downstream accepts `m_data` when `m_valid` & `m_ready`.
REQ-012 Port rd_count  output  $clog2(DEPTH)+8  count of words delivered downstream, wraps modulo 2^width.

Function
REQ-013 The FIFO read latency is fixed at 1 cycle; data returned for a read cycle N is captured at the end of cycle N+1.
REQ-014 Data storage is a 2-entry output buffer; occupancy FSM states are EMPTY (0), ONE (1), TWO (2).
REQ-015 A 1-bit inflight flag is set the cycle after `r_en`=1 and is clear otherwise.
REQ-016 `r_en` is combinational: `en` & !`empty` & (occ + inflight - pop) < 2, where pop = `m_valid` & `m_ready`.
REQ-017 `r_en` is never 1 while `empty`=1 (no underflow).
REQ-018 Buffer write: when inflight=1, `data_out` is written to the tail at the clock edge.
REQ-019 `m_valid` = (occ != 0); `m_data` = head entry; both come from registers only, with no combinational path from `data_out`.
REQ-020 FSM transitions: push only -> occ+1; pop only -> occ-1; push & pop -> occ unchanged, head advances.
REQ-021 Word order is preserved exactly: FIFO read order equals stream order.
REQ-022 `m_data` stays stable while `m_valid`=1 and `m_ready`=0.
REQ-023 Throughput: with `empty`=0, `en`=1 and `m_ready`=1, one word is delivered per cycle in steady state.
REQ-024 First-word latency from `empty` falling (with `en`=1 and the block idle) to `m_valid` rising is 2 cycles.
REQ-025 Deasserting `en` stops `r_en` in the same cycle; the inflight word is still captured and the buffered words are still delivered.
REQ-026 `rd_count` increments by 1 on each pop and wraps to 0 after its maximum value.

Reset
REQ-027 While `rst_n`=0 at a clock edge: occ=0 (EMPTY), inflight=0, `rd_count`=0, `m_valid`=0, buffer contents don't-care.
REQ-028 `r_en`=0 while `rst_n`=0.
REQ-029 A reset mid-operation discards the buffered word and the inflight word; the FIFO-side data loss is accepted.

Structure
REQ-030 Shared package fifo_pkg holds the WIDTH/DEPTH default localparams and the enum occ_state_t {EMPTY, ONE, TWO}.
REQ-031 The 2-entry buffer is a sub-module named stream_skid_buf: push, pop, din, dout, occupancy state.
REQ-032 The top level holds the `r_en` credit logic, the inflight flag and `rd_count`.

Verification
REQ-033 Write 0x11,0x22,0x33 into the FIFO with `m_ready`=1 -> stream delivers 0x11,0x22,0x33 on consecutive cycles; first `m_valid` 2 cycles after `empty` falls; `rd_count`=3.
REQ-034 Fill the FIFO with 8 words, `m_ready`=0 -> exactly 2 reads issued, occ=TWO, `m_data`=word0 held stable; then `m_ready`=1 -> 8 words in order over 8 consecutive cycles.
REQ-035 FIFO empty, `en`=1 for 20 cycles -> `r_en` never 1, `m_valid`=0.
REQ-036 Drop `en` mid-stream while inflight=1 -> inflight word delivered after the buffered words; no further `r_en`; `rd_count` = reads issued.
REQ-037 Assert `rst_n`=0 for 1 cycle with occ=TWO and inflight=1 -> next cycle `m_valid`=0, `rd_count`=0; after release, normal reads resume.
REQ-038 Random `m_ready` (50%) over 1000 words, with the FIFO kept non-empty -> scoreboard shows no loss, duplication or reordering; `rd_count` = 1000 mod 2^11.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: default sizes and the
// occupancy encoding of the 2-entry output buffer.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // Number of words held for a given occupancy state.
  function automatic logic [1:0] occ_level(occ_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO-side and stream-side signals of the reader bundled together.
// master: the reader itself; slave: the FIFO plus downstream consumer.
interface fifo_stream_reader_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 8;

  logic             en;
  logic             r_en;
  logic             empty;
  logic [WIDTH-1:0] data_out;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;
  logic [CW-1:0]    rd_count;

  modport master (
    input  en, empty, data_out, m_ready,
    output r_en, m_valid, m_data, rd_count
  );

  modport slave (
    output en, empty, data_out, m_ready,
    input  r_en, m_valid, m_data, rd_count
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry output buffer holding words returned by the FIFO until the
// downstream consumer takes them. Head/data come straight from registers.
//
// state | meaning
// EMPTY | no word held, m_valid low
// ONE   | one word held at head
// TWO   | both entries full, head is the older word
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output occ_state_t       occ_o
);

  occ_state_t       occ_q, occ_d;
  logic             hd_q, hd_d;
  logic [WIDTH-1:0] mem_q [2];
  logic             do_pop;
  logic             do_push;
  logic             wr_idx;

  // Next occupancy and head pointer; a pop frees the head slot, so the tail
  // slot is head^1 only when exactly one word is held.
  always_comb begin
    do_pop  = pop_i && (occ_q != EMPTY);
    do_push = push_i && ((occ_q != TWO) || do_pop);
    wr_idx  = hd_q ^ (occ_q == ONE);
    occ_d   = occ_q;
    hd_d    = hd_q;
    if (do_pop) begin
      hd_d = ~hd_q;
    end
    unique case ({do_push, do_pop})
      2'b10:   occ_d = (occ_q == EMPTY) ? ONE : TWO;
      2'b01:   occ_d = (occ_q == TWO) ? ONE : EMPTY;
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy state and head pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= EMPTY;
      hd_q  <= 1'b0;
    end else begin
      occ_q <= occ_d;
      hd_q  <= hd_d;
    end
  end

  // Storage entries; contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din_i;
    end
  end

  assign dout_o  = mem_q[hd_q];
  assign valid_o = (occ_q != EMPTY);
  assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a 1-cycle-latency synchronous FIFO and presents its words as a
// valid/ready stream. Reads are issued only when the output buffer is
// guaranteed room for the returning word, so nothing is ever dropped.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_stream_reader_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 8;

  logic             inflight_q, inflight_d;
  logic [CW-1:0]    rd_count_q, rd_count_d;
  logic             pop;
  logic             r_en;
  logic             credit;
  logic [2:0]       level;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_data;
  occ_state_t       occ;

  stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .din_i   (bus.data_out),
    .dout_o  (buf_data),
    .valid_o (buf_valid),
    .occ_o   (occ)
  );

  // Read credit: held words plus the word in flight, minus a word leaving
  // this cycle, must stay below the buffer depth of two.
  always_comb begin
    pop        = buf_valid && bus.m_ready;
    level      = {1'b0, occ_level(occ)} + {2'b00, inflight_q};
    credit     = pop ? (level < 3'd3) : (level < 3'd2);
    r_en       = rst_n && bus.en && !bus.empty && credit;
    inflight_d = r_en;
    rd_count_d = pop ? rd_count_q + CW'(1) : rd_count_q;
  end

  // Inflight flag and delivered-word counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      rd_count_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign bus.r_en     = r_en;
  assign bus.m_valid  = buf_valid;
  assign bus.m_data   = buf_data;
  assign bus.rd_count = rd_count_q;

endmodule
